arbitro_mux_rr: RTL and testbench

Parametrised successor to the two-VC/two-destination arbiter-mux in the PCIe transmit path. Arbitrates among NUM_VC virtual-channel FIFOs using strict priority or round-robin, and generates the pop itself. It routes each popped word to one of NUM_DEST downstream FIFOs by a destination field inside the word. Sits between the VC FIFO bank and the destination (D) FIFO bank, honouring downstream almost-full backpressure.

---
 rtl/arbitro_mux_rr.sv | 155 +++++++++++++++
 tb/tb_arbitro_mux_rr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux_rr.sv
// VC-to-destination arbiter-mux: picks one non-empty VC FIFO per cycle, pops it, and routes
// the word to the destination FIFO selected by its embedded destination field. Optional ARB_STATS_EN adds saturating counters.
module arbitro_mux_rr #(
    parameter int NUM_VC   = 4,
    parameter int NUM_DEST = 4,
    parameter int DATA_W   = 6,
    parameter int DEST_LSB = 4,
    parameter int DEST_W   = 2,
    parameter int ARB_MODE = 1,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_VC*DATA_W-1:0]   vc_data,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_DEST-1:0]        dest_afull,
    output logic [NUM_VC-1:0]          vc_pop,
    output logic [NUM_DEST*DATA_W-1:0] d_data,
    output logic [NUM_DEST-1:0]        d_push,
    output logic                       drop_err,
    output logic [NUM_DEST*CNT_W-1:0]  d_count,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int VC_IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [VC_IDX_W-1:0] LAST_VC = VC_IDX_W'(NUM_VC - 1);

    logic [VC_IDX_W-1:0]        rr_ptr;
    logic [VC_IDX_W-1:0]        grant_idx;
    logic [VC_IDX_W-1:0]        scan_idx;
    logic [VC_IDX_W-1:0]        in_flight_vc;
    logic                       grant_valid;
    logic                       in_flight_valid;
    logic                       stall;
    logic [DATA_W-1:0]          flight_word;
    logic [DEST_W-1:0]          flight_dest;
    logic                       dest_ok;
    logic [NUM_DEST-1:0]        push_next;
    logic [NUM_DEST*DATA_W-1:0] data_next;

    // Any almost-full destination freezes all pops; the 2-entry margin absorbs the in-flight word.
    assign stall = |dest_afull;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = rr_ptr;
        if (!reset && !stall) begin
            if (ARB_MODE == 0) begin
                for (int i = NUM_VC - 1; i >= 0; i--) begin
                    if (!vc_empty[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = VC_IDX_W'(i);
                    end
                end
            end else begin
                // Scan starts just after the last winner so every VC gets a turn.
                for (int k = 0; k < NUM_VC; k++) begin
                    scan_idx = (scan_idx == LAST_VC) ? '0 : scan_idx + 1'b1;
                    if (!grant_valid && !vc_empty[scan_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = scan_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        vc_pop = '0;
        if (grant_valid) begin
            vc_pop[grant_idx] = 1'b1;
        end
    end

    // The popped VC presents its word one cycle later; pick that lane and decode the destination.
    always_comb begin
        flight_word = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (in_flight_vc == VC_IDX_W'(i)) begin
                flight_word = vc_data[i*DATA_W +: DATA_W];
            end
        end
        flight_dest = flight_word[DEST_LSB +: DEST_W];
        dest_ok     = (32'(flight_dest) < 32'(NUM_DEST));
    end

    always_comb begin
        push_next = '0;
        data_next = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            if (in_flight_valid && dest_ok && (32'(flight_dest) == 32'(k))) begin
                push_next[k]                  = 1'b1;
                data_next[k*DATA_W +: DATA_W] = flight_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr          <= LAST_VC;
            in_flight_valid <= 1'b0;
            in_flight_vc    <= '0;
            d_push          <= '0;
            d_data          <= '0;
            drop_err        <= 1'b0;
        end else begin
            in_flight_valid <= grant_valid;
            in_flight_vc    <= grant_idx;
            if (grant_valid) begin
                rr_ptr <= grant_idx;
            end
            d_push   <= push_next;
            d_data   <= data_next;
            drop_err <= in_flight_valid && !dest_ok;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] d_cnt_q [NUM_DEST];
    logic [CNT_W-1:0] drop_cnt_q;

    // Counters advance together with the registered push/drop so they match the visible outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_DEST; k++) begin
                d_cnt_q[k] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_DEST; k++) begin
                if (push_next[k] && (d_cnt_q[k] != '1)) begin
                    d_cnt_q[k] <= d_cnt_q[k] + 1'b1;
                end
            end
            if (in_flight_valid && !dest_ok && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        d_count = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            d_count[k*CNT_W +: CNT_W] = d_cnt_q[k];
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign d_count    = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_arbitro_mux_rr.sv
// Bench for arbitro_mux_rr: a round-robin instance (4 dests) and a strict-priority instance (3 dests)
// fed from modelled VC FIFOs and checked every cycle against a queue-based reference.
module tb_arbitro_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  vc_empty_b [2];
    logic [23:0] vc_data_b  [2];
    logic [3:0]  afull_b    [2];

    logic [3:0]  vc_pop_b   [2];
    logic [3:0]  d_push_b   [2];
    logic [23:0] d_data_b   [2];
    logic        drop_b     [2];
    logic [31:0] dcnt_b     [2];
    logic [7:0]  dropcnt_b  [2];

    logic [3:0]  rr_pop, sp_pop;
    logic [3:0]  rr_push;
    logic [2:0]  sp_push;
    logic [23:0] rr_data;
    logic [17:0] sp_data;
    logic        rr_drop, sp_drop;
    logic [31:0] rr_cnt;
    logic [23:0] sp_cnt;
    logic [7:0]  rr_dcnt, sp_dcnt;

    arbitro_mux_rr #(.NUM_VC(4), .NUM_DEST(4), .DATA_W(6), .DEST_LSB(4), .DEST_W(2),
                     .ARB_MODE(1), .CNT_W(8)) u_rr (
        .clk(clk), .reset(reset), .vc_data(vc_data_b[0]), .vc_empty(vc_empty_b[0]),
        .dest_afull(afull_b[0]), .vc_pop(rr_pop), .d_data(rr_data), .d_push(rr_push),
        .drop_err(rr_drop), .d_count(rr_cnt), .drop_count(rr_dcnt));

    arbitro_mux_rr #(.NUM_VC(4), .NUM_DEST(3), .DATA_W(6), .DEST_LSB(4), .DEST_W(2),
                     .ARB_MODE(0), .CNT_W(8)) u_sp (
        .clk(clk), .reset(reset), .vc_data(vc_data_b[1]), .vc_empty(vc_empty_b[1]),
        .dest_afull(afull_b[1][2:0]), .vc_pop(sp_pop), .d_data(sp_data), .d_push(sp_push),
        .drop_err(sp_drop), .d_count(sp_cnt), .drop_count(sp_dcnt));

    assign vc_pop_b[0]  = rr_pop;
    assign vc_pop_b[1]  = sp_pop;
    assign d_push_b[0]  = rr_push;
    assign d_push_b[1]  = {1'b0, sp_push};
    assign d_data_b[0]  = rr_data;
    assign d_data_b[1]  = {6'b0, sp_data};
    assign drop_b[0]    = rr_drop;
    assign drop_b[1]    = sp_drop;
    assign dcnt_b[0]    = rr_cnt;
    assign dcnt_b[1]    = {8'b0, sp_cnt};
    assign dropcnt_b[0] = rr_dcnt;
    assign dropcnt_b[1] = sp_dcnt;

    int nd   [2] = '{4, 3};
    int mode [2] = '{1, 0};

    logic [5:0] q  [2][4][$];
    logic [5:0] rd [2][4];

    int         ptr      [2];
    bit         s1_v     [2];
    logic [5:0] s1_w     [2];
    int         e_pop    [2];
    logic [5:0] e_word   [2];
    logic [3:0] e_push   [2];
    logic [23:0] e_data  [2];
    bit         e_drop   [2];
    int         e_cnt    [2][4];
    int         e_dropcnt[2];
    bit         model_ok;
    logic [3:0] pop_s    [2];
    bit         reset_s;
    int         cyc;

    int pop_log   [2][$];
    int pop_cyc   [2][$];
    int push_dest [2][$];
    int push_data [2][$];
    int push_cyc  [2][$];
    int drop_seen [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic refreshInputs();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 4; i++) begin
                vc_empty_b[j][i]       = (q[j][i].size() == 0);
                vc_data_b[j][i*6 +: 6] = rd[j][i];
            end
        end
    endtask

    // Reference grant: strict = lowest non-empty VC, round-robin = first non-empty after the last winner.
    task automatic predictPop();
        for (int j = 0; j < 2; j++) begin
            int mask;
            mask     = (1 << nd[j]) - 1;
            e_pop[j] = -1;
            if (!reset && ((int'(afull_b[j]) & mask) == 0)) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (mode[j] == 0) ? (k - 1) : ((ptr[j] + k) % 4);
                    if (e_pop[j] < 0 && q[j][i].size() > 0) e_pop[j] = i;
                end
            end
            if (e_pop[j] >= 0) e_word[j] = q[j][e_pop[j]][0];
        end
    endtask

    task automatic checkOutput();
        if (model_ok) begin
            for (int j = 0; j < 2; j++) begin
                logic [31:0] exp_cnt;
                logic [3:0]  exp_pop;
                exp_pop = (e_pop[j] >= 0) ? 4'(1 << e_pop[j]) : 4'h0;
                exp_cnt = '0;
`ifdef ARB_STATS_EN
                for (int k = 0; k < nd[j]; k++) exp_cnt[k*8 +: 8] = 8'(e_cnt[j][k]);
                check($sformatf("drop_count%0d", j), 32'(dropcnt_b[j]), 32'(e_dropcnt[j]));
`else
                check($sformatf("drop_count%0d", j), 32'(dropcnt_b[j]), 32'd0);
`endif
                check($sformatf("vc_pop%0d", j), 32'(vc_pop_b[j]), 32'(exp_pop));
                check($sformatf("d_push%0d", j), 32'(d_push_b[j]), 32'(e_push[j]));
                check($sformatf("d_data%0d", j), 32'(d_data_b[j]), 32'(e_data[j]));
                check($sformatf("drop_err%0d", j), 32'(drop_b[j]), 32'(e_drop[j]));
                check($sformatf("d_count%0d", j), dcnt_b[j], exp_cnt);
                for (int i = 0; i < 4; i++) begin
                    if (vc_pop_b[j][i]) begin
                        pop_log[j].push_back(i);
                        pop_cyc[j].push_back(cyc);
                    end
                    if (d_push_b[j][i]) begin
                        push_dest[j].push_back(i);
                        push_data[j].push_back(int'(d_data_b[j][i*6 +: 6]));
                        push_cyc[j].push_back(cyc);
                    end
                end
                if (drop_b[j]) drop_seen[j]++;
            end
        end
    endtask

    task automatic commitModel();
        for (int j = 0; j < 2; j++) begin
            e_push[j] = '0;
            e_data[j] = '0;
            e_drop[j] = 1'b0;
            if (reset_s) begin
                ptr[j]       = 3;
                s1_v[j]      = 1'b0;
                e_dropcnt[j] = 0;
                for (int k = 0; k < 4; k++) e_cnt[j][k] = 0;
            end else begin
                if (s1_v[j]) begin
                    int d;
                    d = int'(s1_w[j]) / 16;
                    if (d < nd[j]) begin
                        e_push[j][d]       = 1'b1;
                        e_data[j][d*6 +: 6] = s1_w[j];
                        if (e_cnt[j][d] < 255) e_cnt[j][d]++;
                    end else begin
                        e_drop[j] = 1'b1;
                        if (e_dropcnt[j] < 255) e_dropcnt[j]++;
                    end
                end
                s1_v[j] = (e_pop[j] >= 0);
                s1_w[j] = e_word[j];
                if (e_pop[j] >= 0 && mode[j] == 1) ptr[j] = e_pop[j];
            end
        end
        model_ok = 1'b1;
    endtask

    task automatic cycle();
        refreshInputs();
        @(negedge clk);
        predictPop();
        checkOutput();
        reset_s = reset;
        pop_s   = vc_pop_b;
        @(posedge clk);
        commitModel();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++)
                if (pop_s[j][i] && q[j][i].size() > 0) rd[j][i] = q[j][i].pop_front();
        #1;
        cyc++;
    endtask

    task automatic applyStimulus();
        reset = ($urandom_range(0, 199) == 0);
        for (int j = 0; j < 2; j++) begin
            afull_b[j] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            for (int i = 0; i < 4; i++)
                if (q[j][i].size() < 4 && $urandom_range(0, 2) == 0)
                    q[j][i].push_back(6'($urandom_range(0, 63)));
        end
        cycle();
    endtask

    task automatic clearLogs();
        for (int j = 0; j < 2; j++) begin
            pop_log[j].delete();
            pop_cyc[j].delete();
            push_dest[j].delete();
            push_data[j].delete();
            push_cyc[j].delete();
            drop_seen[j] = 0;
        end
    endtask

    initial begin
        int r0, t, stall_pops, pushed_in_stall, resumed;
        cyc      = 0;
        model_ok = 1'b0;
        reset    = 1'b1;
        for (int j = 0; j < 2; j++) begin
            afull_b[j] = 4'h0;
            for (int i = 0; i < 4; i++) begin
                rd[j][i] = 6'h00;
                q[j][i].push_back(6'h01);
            end
        end

        repeat (3) cycle();
        check("reset_pop_rr", 32'(vc_pop_b[0]), 32'd0);
        check("reset_pop_sp", 32'(vc_pop_b[1]), 32'd0);
        check("reset_push_rr", 32'(d_push_b[0]), 32'd0);
        check("reset_data_rr", 32'(d_data_b[0]), 32'd0);

        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) q[j][i].delete();
        q[0][0].push_back(6'h15); q[0][0].push_back(6'h01);
        q[0][1].push_back(6'h2A);
        q[0][2].push_back(6'h05);
        q[0][3].push_back(6'h3F);
        q[1][0].push_back(6'h05); q[1][0].push_back(6'h06);
        q[1][2].push_back(6'h2A);
        cycle();
        reset = 1'b0;
        clearLogs();
        r0 = cyc;
        repeat (8) cycle();

        check("rr_pop_count", 32'(pop_log[0].size()), 32'd5);
        check("rr_pop0", 32'(pop_log[0][0]), 32'd0);
        check("rr_pop1", 32'(pop_log[0][1]), 32'd1);
        check("rr_pop2", 32'(pop_log[0][2]), 32'd2);
        check("rr_pop3", 32'(pop_log[0][3]), 32'd3);
        check("rr_pop4", 32'(pop_log[0][4]), 32'd0);
        check("rr_first_pop_cycle", 32'(pop_cyc[0][0]), 32'(r0));
        check("rr_push0_dest", 32'(push_dest[0][0]), 32'd1);
        check("rr_push0_data", 32'(push_data[0][0]), 32'h15);
        check("rr_push1_dest", 32'(push_dest[0][1]), 32'd2);
        check("rr_push1_data", 32'(push_data[0][1]), 32'h2A);
        check("sp_pop_count", 32'(pop_log[1].size()), 32'd3);
        check("sp_pop0", 32'(pop_log[1][0]), 32'd0);
        check("sp_pop1", 32'(pop_log[1][1]), 32'd0);
        check("sp_pop2", 32'(pop_log[1][2]), 32'd2);
        check("sp_push0_dest", 32'(push_dest[1][0]), 32'd0);
        check("sp_push0_data", 32'(push_data[1][0]), 32'h05);
        check("sp_latency", 32'(push_cyc[1][0] - pop_cyc[1][0]), 32'd2);
        check("sp_push2_dest", 32'(push_dest[1][2]), 32'd2);

        q[1][1].push_back(6'h3F);
        repeat (4) cycle();
        check("sp_drop_seen", 32'(drop_seen[1]), 32'd1);
        check("sp_push_total", 32'(push_dest[1].size()), 32'd3);
`ifdef ARB_STATS_EN
        check("sp_drop_count", 32'(dropcnt_b[1]), 32'd1);
        check("sp_d_count", dcnt_b[1], 32'h0001_0002);
`endif

        for (int i = 0; i < 4; i++) begin
            q[0][i].push_back(6'(6'h10 + i));
            q[0][i].push_back(6'(6'h20 + i));
        end
        clearLogs();
        t = cyc;
        cycle();
        afull_b[0] = 4'b1000;
        repeat (4) cycle();
        afull_b[0] = 4'b0000;
        repeat (2) cycle();
        stall_pops      = 0;
        pushed_in_stall = 0;
        resumed         = 0;
        foreach (pop_cyc[0][k]) begin
            if (pop_cyc[0][k] >= t + 1 && pop_cyc[0][k] <= t + 4) stall_pops++;
            if (pop_cyc[0][k] == t + 5) resumed++;
        end
        foreach (push_cyc[0][k])
            if (push_cyc[0][k] == t + 2) pushed_in_stall++;
        check("bp_pop_at_start", 32'(pop_cyc[0][0]), 32'(t));
        check("bp_no_pops", 32'(stall_pops), 32'd0);
        check("bp_inflight_push", 32'(pushed_in_stall), 32'd1);
        check("bp_resume", 32'(resumed), 32'd1);

        repeat (3000) applyStimulus();
        reset = 1'b0;
        for (int j = 0; j < 2; j++) afull_b[j] = 4'h0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
